mul_div_unit: RTL and testbench

Iterative RV32M/RV64M multiply–divide unit, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and handles the eight M-extension operations selected by `funct3` (opcode 0110011, `funct7` = 0000001). The unit runs a shift-add multiplier and a restoring divider over XLEN cycles, under a start/busy/done handshake. The core must stall while `busy` is high.

---
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring
// divider on operand magnitudes, one iteration per cycle, start/busy/done handshake.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: start is taken only in IDLE without flush; busy covers every
  // cycle from acceptance+1 through the done cycle; done pulses for one cycle
  // with result valid alongside it, and flush cancels done in that same cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_V    = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                byp_q, byp_d;
  logic [XLEN-1:0]     byp_res_q, byp_res_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div, div_zero, div_ovf, bypass;
  logic [XLEN-1:0]     byp_val;
  logic [XLEN:0]       mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quot, rem, fin;

  // Operand decode at acceptance
  always_comb begin
    a_signed = ~funct3[0] | (funct3 == 3'b001);
    b_signed = (funct3[2] & ~funct3[0]) | (funct3[2:1] == 2'b00);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    is_div   = funct3[2];
    div_zero = (op_b == '0);
    div_ovf  = ~funct3[0] & (op_a == MIN_V) & (op_b == ONES);
    bypass   = is_div & (div_zero | div_ovf);
    if (div_zero) byp_val = funct3[1] ? op_a : ONES;
    else          byp_val = funct3[1] ? '0 : MIN_V;
  end

  // One iteration of each datapath; acc holds {hi, lo} for both
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, b_q};
    if (div_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection from the finished datapath
  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quot = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem  = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    fin  = '0;
    if (byp_q) begin
      fin = byp_res_q;
    end else begin
      case (f3_q)
        3'b000:                 fin = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         fin = quot;
        default:                fin = rem;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    acc_d     = acc_q;
    b_d       = b_q;
    byp_d     = byp_q;
    byp_res_d = byp_res_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d      = funct3;
          sa_d      = a_neg;
          sb_d      = b_neg;
          b_d       = b_mag;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          byp_d     = bypass;
          byp_res_d = byp_val;
          if (bypass) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = f3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!flush) result_d = fin;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      byp_q     <= 1'b0;
      byp_res_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      byp_q     <= byp_d;
      byp_res_q <= byp_res_d;
      result_q  <= result_d;
    end
  end

  // The fresh value is visible during the done cycle itself
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) && !flush;
  assign result    = done ? fin : result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: literal test-plan vectors, flush/reset/ignored-start
// cases and random operations, all checked every cycle against a plain-arithmetic model.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN32 = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done;
  logic [1:0]   dbg_state;

  logic         start64, busy64, done64;
  logic [2:0]   f3_64;
  logic [63:0]  a64, b64, res64;
  logic [1:0]   dbg64;

  mul_div_unit #(.XLEN(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result), .dbg_state(dbg_state));

  mul_div_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .funct3(f3_64), .op_a(a64), .op_b(b64),
    .flush(1'b0), .busy(busy64), .done(done64), .result(res64), .dbg_state(dbg64));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int m_acc = -100;
  int m_end = -100;
  bit m_cancel = 1'b1;
  logic [W-1:0] last_res = '0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint as_, bs_;
    logic [63:0] au, bu, p;
    as_ = longint'($signed(a));
    bs_ = longint'($signed(b));
    au  = {32'b0, a};
    bu  = {32'b0, b};
    p   = '0;
    case (f)
      3'd0: begin p = as_ * bs_; return p[31:0]; end
      3'd1: begin p = as_ * bs_; return p[63:32]; end
      3'd2: begin p = as_ * longint'(bu); return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN32 && b == '1) return MIN32;
        p = as_ / bs_; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = au / bu; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == '1) return '0;
        p = as_ % bs_; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = au % bu; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_bypass(input logic [2:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    return f[2] && (b == 0 || (!f[0] && a == MIN32 && b == '1));
  endfunction

  // Every-cycle compare: busy window, done pulse, result value/hold
  always @(negedge clk) begin
    if (check_en) begin
      bit exp_busy, exp_done;
      logic [W-1:0] e;
      exp_busy = (cyc > m_acc) && (cyc <= m_end);
      exp_done = !m_cancel && (cyc == m_end);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (exp_done) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("result_done", result, e);
          last_res = e;
        end
      end else begin
        chk("result_hold", result, last_res);
      end
      if (reset) last_res = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    while (cyc <= m_end) tick();
  endtask

  task automatic issue_exp(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e);
    wait_idle();
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    m_acc    = cyc;
    m_end    = cyc + (is_bypass(f, a, b) ? 1 : W + 1);
    m_cancel = 1'b0;
    exp_q.push_back(e);
    tick();
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_exp(f, a, b, model(f, a, b));
  endtask

  task automatic pin(input string name, input logic [2:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] lit);
    chk({"model_", name}, model(f, a, b), lit);
    issue_exp(f, a, b, lit);
  endtask

  task automatic cancel_here();
    m_end    = cyc;
    m_cancel = 1'b1;
    void'(exp_q.pop_back());
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MIN32;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int c0, got;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    start64 = 1'b0; f3_64 = '0; a64 = '0; b64 = '0;
    tick();
    tick();
    reset    = 1'b0;
    check_en = 1'b1;
    tick();

    pin("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    pin("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    pin("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    pin("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pin("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    pin("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    pin("divu",   3'd5, 32'd100, 32'd7, 32'd14);
    pin("remu",   3'd7, 32'd100, 32'd7, 32'd2);
    pin("div0",   3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    pin("remu0",  3'd7, 32'd5, 32'd0, 32'd5);
    pin("divovf", 3'd4, MIN32, 32'hFFFF_FFFF, MIN32);
    pin("removf", 3'd6, MIN32, 32'hFFFF_FFFF, 32'd0);

    // Flush in the 10th cycle of a DIV
    issue(3'd4, 32'd1000, 32'd3);
    while (cyc < m_acc + 10) tick();
    flush = 1'b1;
    cancel_here();
    tick();
    flush = 1'b0;

    // start during a MUL is ignored
    issue(3'd0, 32'd12345, 32'hFFFF_0001);
    while (cyc < m_acc + 5) tick();
    start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
    tick();
    start = 1'b0;

    // start in the done cycle is ignored
    wait_idle();
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    while (cyc < m_end) tick();
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1; op_b = 32'd0;
    tick();
    start = 1'b0;

    // flush together with start in IDLE accepts nothing
    wait_idle();
    start = 1'b1; flush = 1'b1; funct3 = 3'd7; op_a = 32'd8; op_b = 32'd0;
    tick();
    start = 1'b0; flush = 1'b0;
    tick();

    // flush in the done cycle suppresses done and keeps result
    issue(3'd3, 32'h0001_0000, 32'h0001_0000);
    while (cyc < m_end) tick();
    flush = 1'b1;
    cancel_here();
    tick();
    flush = 1'b0;

    // flush during a bypass done cycle
    issue(3'd5, 32'd77, 32'd0);
    flush = 1'b1;
    cancel_here();
    tick();
    flush = 1'b0;

    // reset mid-calculation, then MUL 3x4
    issue(3'd2, 32'hFFFF_FF00, 32'd55);
    while (cyc < m_acc + 8) tick();
    reset = 1'b1;
    cancel_here();
    tick();
    reset = 1'b0;
    pin("mul34", 3'd0, 32'd3, 32'd4, 32'd12);

    // randomized operations with random idle gaps
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_idle();
    tick();

    // XLEN = 64 MULHU of all-ones squared
    start64 = 1'b1; f3_64 = 3'd3; a64 = '1; b64 = '1;
    c0 = cyc;
    tick();
    start64 = 1'b0; a64 = '0; b64 = '0;
    got = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done64) begin
        got = cyc;
        chk("x64_result", res64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("x64_busy_at_done", busy64, 1'b1);
        break;
      end
    end
    chk("x64_latency", 64'(got - c0), 64'd65);
    tick();
    tick();
    chk("x64_idle_after", busy64, 1'b0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
